// File: rtl/collision_ctrl_if.sv
// Bus bundle between collision_ctrl and its surroundings: strobes, player/obstacle boxes, game outputs.
// The master drives the boxes and strobes; the slave (collision_ctrl) produces the game events.
interface collision_ctrl_if #(
   parameter int NUM_OBS = 4
);
   logic                   i_ani_stb;
   logic                   i_animate;
   logic                   i_restart;
   logic [11:0]            i_px1;
   logic [11:0]            i_px2;
   logic [11:0]            i_py1;
   logic [11:0]            i_py2;
   logic [12*NUM_OBS-1:0]  i_ox1;
   logic [12*NUM_OBS-1:0]  i_ox2;
   logic [12*NUM_OBS-1:0]  i_oy1;
   logic [12*NUM_OBS-1:0]  i_oy2;
   logic                   o_hit;
   logic                   o_respawn;
   logic                   o_freeze;
   logic                   o_game_over;
   logic [3:0]             o_lives;

   modport master (
      output i_ani_stb, i_animate, i_restart,
      output i_px1, i_px2, i_py1, i_py2,
      output i_ox1, i_ox2, i_oy1, i_oy2,
      input  o_hit, o_respawn, o_freeze, o_game_over, o_lives
   );

   modport slave (
      input  i_ani_stb, i_animate, i_restart,
      input  i_px1, i_px2, i_py1, i_py2,
      input  i_ox1, i_ox2, i_oy1, i_oy2,
      output o_hit, o_respawn, o_freeze, o_game_over, o_lives
   );
endinterface

// File: rtl/collision_ctrl.sv
// collision_ctrl: scans NUM_OBS obstacle boxes against the player with one shared comparator per strobe
// and turns overlaps into hit/lives/freeze/respawn/game-over events. Define COLLIDE_GRACE_EN for post-respawn grace.
module collision_ctrl #(
   parameter int NUM_OBS    = 4,
   parameter int LIVES      = 3,
   parameter int HIT_FRAMES = 60
`ifdef COLLIDE_GRACE_EN
   ,
   parameter int GRACE_FRAMES = 90
`endif
) (
   input logic             i_clk,
   input logic             i_rst_n,
   collision_ctrl_if.slave bus
);

   typedef enum logic [1:0] {SIDLE, SCAN, SDONE} scan_state_t;
   typedef enum logic [1:0] {PLAY, HIT, OVER}    game_state_t;

   localparam logic [3:0] LAST_IDX   = 4'(NUM_OBS - 1);
   localparam logic [3:0] LIVES_LOAD = 4'(LIVES);
   localparam logic [7:0] HIT_LOAD   = 8'(HIT_FRAMES);

   scan_state_t scan_state, scan_next;
   game_state_t game_state, game_next;

   logic [3:0]  idx, idx_next;
   logic        acc, acc_next;
   logic        scan_start;
   logic        scan_done;
   logic        scan_discard;

   logic [11:0] ox1_sel, ox2_sel, oy1_sel, oy2_sel;
   logic [11:0] ox1_eff;
   logic        overlap;

   logic [3:0]  lives, lives_next;
   logic [7:0]  frame_cnt, frame_cnt_next;
   logic        hit_q, hit_next;
   logic        respawn_q, respawn_next;

   // Obstacle mux for the shared comparator; a left edge above the right edge has wrapped past 0.
   always_comb begin
      ox1_sel = '0;
      ox2_sel = '0;
      oy1_sel = '0;
      oy2_sel = '0;
      for (int k = 0; k < NUM_OBS; k++) begin
         if (idx == 4'(k)) begin
            ox1_sel = bus.i_ox1[12*k +: 12];
            ox2_sel = bus.i_ox2[12*k +: 12];
            oy1_sel = bus.i_oy1[12*k +: 12];
            oy2_sel = bus.i_oy2[12*k +: 12];
         end
      end
      ox1_eff = (ox1_sel > ox2_sel) ? 12'd0 : ox1_sel;
      overlap = (bus.i_px1 < ox2_sel) && (bus.i_px2 > ox1_eff) &&
                (bus.i_py1 < oy2_sel) && (bus.i_py2 > oy1_sel);
   end

   assign scan_start = (scan_state == SIDLE) && bus.i_ani_stb && bus.i_animate;
   assign scan_done  = (scan_state == SDONE);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         scan_state <= SIDLE;
         idx        <= '0;
         acc        <= 1'b0;
      end else begin
         scan_state <= scan_next;
         idx        <= idx_next;
         acc        <= acc_next;
      end
   end

   always_comb begin
      scan_next = scan_state;
      idx_next  = idx;
      acc_next  = acc;
      case (scan_state)
         SIDLE: begin
            if (scan_start) begin
               scan_next = SCAN;
               idx_next  = '0;
               acc_next  = 1'b0;
            end
         end
         SCAN: begin
            acc_next = acc | overlap;
            idx_next = idx + 4'd1;
            if (idx == LAST_IDX) begin
               scan_next = SDONE;
            end
         end
         SDONE: begin
            scan_next = SIDLE;
         end
         default: begin
            scan_next = SIDLE;
         end
      endcase
   end

`ifdef COLLIDE_GRACE_EN
   localparam logic [7:0] GRACE_LOAD = 8'(GRACE_FRAMES);

   logic [7:0] grace_cnt;
   logic       scan_masked;

   // The mask is captured at scan start so a scan begun on the last grace strobe is still discarded.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         grace_cnt   <= '0;
         scan_masked <= 1'b0;
      end else begin
         if (respawn_next) begin
            grace_cnt <= GRACE_LOAD;
         end else if ((game_state == PLAY) && bus.i_ani_stb && (grace_cnt != 8'd0)) begin
            grace_cnt <= grace_cnt - 8'd1;
         end
         if (scan_start) begin
            scan_masked <= (grace_cnt != 8'd0);
         end
      end
   end

   assign scan_discard = scan_masked || (grace_cnt != 8'd0);
`else
   assign scan_discard = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         game_state <= PLAY;
         lives      <= LIVES_LOAD;
         frame_cnt  <= '0;
         hit_q      <= 1'b0;
         respawn_q  <= 1'b0;
      end else begin
         game_state <= game_next;
         lives      <= lives_next;
         frame_cnt  <= frame_cnt_next;
         hit_q      <= hit_next;
         respawn_q  <= respawn_next;
      end
   end

   // A strobe landing on the last frozen frame both decrements and expires in the same cycle.
   always_comb begin
      game_next      = game_state;
      lives_next     = lives;
      frame_cnt_next = frame_cnt;
      hit_next       = 1'b0;
      respawn_next   = 1'b0;
      case (game_state)
         PLAY: begin
            if (scan_done && acc && !scan_discard) begin
               hit_next       = 1'b1;
               lives_next     = (lives == 4'd0) ? 4'd0 : lives - 4'd1;
               frame_cnt_next = HIT_LOAD;
               game_next      = HIT;
            end
         end
         HIT: begin
            if (bus.i_ani_stb) begin
               if (frame_cnt <= 8'd1) begin
                  frame_cnt_next = '0;
                  if (lives == 4'd0) begin
                     game_next = OVER;
                  end else begin
                     respawn_next = 1'b1;
                     game_next    = PLAY;
                  end
               end else begin
                  frame_cnt_next = frame_cnt - 8'd1;
               end
            end
         end
         OVER: begin
            if (bus.i_restart) begin
               lives_next   = LIVES_LOAD;
               respawn_next = 1'b1;
               game_next    = PLAY;
            end
         end
         default: begin
            game_next = PLAY;
         end
      endcase
   end

   assign bus.o_hit       = hit_q;
   assign bus.o_respawn   = respawn_q;
   assign bus.o_freeze    = (game_state != PLAY);
   assign bus.o_game_over = (game_state == OVER);
   assign bus.o_lives     = lives;

endmodule

// File: tb/tb_collision_ctrl.sv
// Scoreboard bench for collision_ctrl: a strobe-level game model predicts each window's events,
// which are queued on drive and compared once the scan window has elapsed.
module tb_collision_ctrl;

   localparam int NUM_OBS      = 4;
   localparam int LIVES        = 3;
   localparam int HIT_FRAMES   = 2;
   localparam int GRACE_FRAMES = 5;
   localparam int WINDOW       = 10;
`ifdef COLLIDE_GRACE_EN
   localparam bit GRACE_ON = 1'b1;
`else
   localparam bit GRACE_ON = 1'b0;
`endif

   typedef enum {M_PLAY, M_HIT, M_OVER} model_state_t;

   typedef struct packed {
      logic       hit;
      logic       respawn;
      logic [3:0] lives;
      logic       freeze;
      logic       over;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   int compare_count = 0;
   int mismatch_count = 0;

   exp_t sb_q[$];

   logic [11:0] px1, px2, py1, py2;
   logic [11:0] ox1_a[NUM_OBS];
   logic [11:0] ox2_a[NUM_OBS];
   logic [11:0] oy1_a[NUM_OBS];
   logic [11:0] oy2_a[NUM_OBS];

   model_state_t m_state = M_PLAY;
   int m_lives = LIVES;
   int m_cnt = 0;
   int m_grace = 0;

   always #5 clk = ~clk;

   collision_ctrl_if #(.NUM_OBS(NUM_OBS)) bus ();

   collision_ctrl #(
      .NUM_OBS      (NUM_OBS),
      .LIVES        (LIVES),
      .HIT_FRAMES   (HIT_FRAMES)
`ifdef COLLIDE_GRACE_EN
      ,
      .GRACE_FRAMES (GRACE_FRAMES)
`endif
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compare_count++;
      if (observed !== expected) begin
         mismatch_count++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic setPlayer(input int x1, input int x2, input int y1, input int y2);
      px1 = 12'(x1); px2 = 12'(x2); py1 = 12'(y1); py2 = 12'(y2);
      bus.i_px1 = px1; bus.i_px2 = px2; bus.i_py1 = py1; bus.i_py2 = py2;
   endtask

   task automatic setObstacle(input int k, input int x1, input int x2, input int y1, input int y2);
      ox1_a[k] = 12'(x1); ox2_a[k] = 12'(x2); oy1_a[k] = 12'(y1); oy2_a[k] = 12'(y2);
      bus.i_ox1[12*k +: 12] = ox1_a[k];
      bus.i_ox2[12*k +: 12] = ox2_a[k];
      bus.i_oy1[12*k +: 12] = oy1_a[k];
      bus.i_oy2[12*k +: 12] = oy2_a[k];
   endtask

   task automatic parkObstacle(input int k);
      setObstacle(k, 3000, 3010, 3000, 3010);
   endtask

   // Reference overlap: strict inequalities, and a wrapped left edge counts as 0.
   function automatic bit modelOverlap();
      logic [11:0] left;
      for (int k = 0; k < NUM_OBS; k++) begin
         left = (ox1_a[k] > ox2_a[k]) ? 12'd0 : ox1_a[k];
         if (px1 < ox2_a[k] && px2 > left && py1 < oy2_a[k] && py2 > oy1_a[k]) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic applyStimulus();
      exp_t e;
      bit ov;
      bit masked;
      ov = bus.i_animate && modelOverlap();
      masked = 1'b0;
      e = '0;
      case (m_state)
         M_HIT: begin
            m_cnt--;
            if (m_cnt == 0) begin
               if (m_lives == 0) begin
                  m_state = M_OVER;
               end else begin
                  e.respawn = 1'b1;
                  m_state = M_PLAY;
                  if (GRACE_ON) begin
                     m_grace = GRACE_FRAMES;
                     masked = 1'b1;
                  end
               end
            end
         end
         M_PLAY: begin
            masked = (m_grace != 0);
            if (m_grace > 0) m_grace--;
         end
         default: ;
      endcase
      if (m_state == M_PLAY && ov && !masked) begin
         e.hit = 1'b1;
         m_lives = (m_lives > 0) ? m_lives - 1 : 0;
         m_cnt = HIT_FRAMES;
         m_state = M_HIT;
      end
      e.lives = 4'(m_lives);
      e.freeze = (m_state != M_PLAY);
      e.over = (m_state == M_OVER);
      sb_q.push_back(e);
      @(negedge clk);
      bus.i_ani_stb = 1'b1;
      @(negedge clk);
      bus.i_ani_stb = 1'b0;
   endtask

   task automatic collectResult();
      exp_t e;
      int hit_cnt, hit_pos, resp_cnt, resp_pos;
      logic fr_hit, fr_resp;
      hit_cnt = 0; hit_pos = -1; resp_cnt = 0; resp_pos = -1;
      fr_hit = 1'b0; fr_resp = 1'b1;
      for (int k = 0; k < WINDOW; k++) begin
         if (k > 0) @(negedge clk);
         if (bus.o_hit === 1'b1) begin
            hit_cnt++;
            if (hit_pos < 0) begin
               hit_pos = k;
               fr_hit = bus.o_freeze;
            end
         end
         if (bus.o_respawn === 1'b1) begin
            resp_cnt++;
            if (resp_pos < 0) begin
               resp_pos = k;
               fr_resp = bus.o_freeze;
            end
         end
      end
      e = sb_q.pop_front();
      checkOutput("hit_pulses", hit_cnt, {31'd0, e.hit});
      if (e.hit) begin
         checkOutput("hit_cycle", hit_pos, NUM_OBS + 1);
         checkOutput("freeze_with_hit", fr_hit, 1);
      end
      checkOutput("respawn_pulses", resp_cnt, {31'd0, e.respawn});
      if (e.respawn) begin
         checkOutput("respawn_cycle", resp_pos, 0);
         checkOutput("freeze_with_respawn", fr_resp, 0);
      end
      checkOutput("lives", bus.o_lives, e.lives);
      checkOutput("freeze", bus.o_freeze, e.freeze);
      checkOutput("game_over", bus.o_game_over, e.over);
   endtask

   task automatic strobeN(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus();
         collectResult();
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_lives"}, bus.o_lives, LIVES);
      checkOutput({tag, "_hit"}, bus.o_hit, 0);
      checkOutput({tag, "_respawn"}, bus.o_respawn, 0);
      checkOutput({tag, "_freeze"}, bus.o_freeze, 0);
      checkOutput({tag, "_game_over"}, bus.o_game_over, 0);
   endtask

   initial begin
      bus.i_ani_stb = 1'b0;
      bus.i_animate = 1'b1;
      bus.i_restart = 1'b0;
      setPlayer(100, 140, 200, 230);
      for (int k = 0; k < NUM_OBS; k++) parkObstacle(k);

      repeat (3) @(negedge clk);
      checkResetValues("reset");
      rst_n = 1'b1;
      @(negedge clk);
      checkResetValues("post_reset");

      // No obstacle near the player.
      strobeN(2);

      // Touching edges in x, then in y, never collide.
      setObstacle(2, 140, 170, 210, 240);
      strobeN(10);
      setObstacle(2, 130, 170, 230, 260);
      strobeN(2);

      // Real overlap while animation is disabled: no scan happens.
      setObstacle(2, 130, 170, 210, 240);
      bus.i_animate = 1'b0;
      strobeN(1);
      bus.i_animate = 1'b1;
      parkObstacle(2);

      // Wrapped obstacle: miss to the right of its true right edge, then hit and ride to game over.
      setObstacle(1, 4090, 15, 200, 240);
      setPlayer(20, 40, 200, 230);
      strobeN(2);
      setPlayer(0, 20, 200, 230);
      strobeN(22);

      // Restart out of game over.
      checkOutput("over_before_restart", bus.o_game_over, (m_state == M_OVER) ? 1 : 0);
      @(negedge clk);
      bus.i_restart = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("restart_respawn", bus.o_respawn, 1);
      checkOutput("restart_lives", bus.o_lives, LIVES);
      checkOutput("restart_freeze", bus.o_freeze, 0);
      checkOutput("restart_game_over", bus.o_game_over, 0);
      @(negedge clk);
      bus.i_restart = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("restart_respawn_width", bus.o_respawn, 0);
      m_state = M_PLAY;
      m_lives = LIVES;
      m_cnt = 0;
      m_grace = GRACE_ON ? GRACE_FRAMES : 0;

      // Reference overlap on obstacle 2, strobing until the model expects the hit.
      parkObstacle(1);
      setPlayer(100, 140, 200, 230);
      setObstacle(2, 130, 170, 210, 240);
      for (int i = 0; i < 8; i++) begin
         applyStimulus();
         collectResult();
         if (m_state == M_HIT) break;
      end

      // Asynchronous reset between edges while frozen.
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkResetValues("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      m_state = M_PLAY;
      m_lives = LIVES;
      m_cnt = 0;
      m_grace = 0;

      // Collisions count again straight after reset.
      strobeN(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

endmodule
